alu_ctrl_seq: RTL and testbench

Next-generation EX-stage ALU control for the pipelined MIPS core, with width-parametrised operands. Single-cycle ops are decoded combinationally to `aluop`, as before. MULT/MULTU/DIV/DIVU are executed by an internal iterative shift-add / restoring-divide engine that writes HI/LO and stalls the pipeline until the result is ready. It sits between the ID/EX stage register and the ALU/HI-LO datapath.

---
 rtl/alu_ctrl_seq_if.sv | 33 +++
 rtl/alu_ctrl_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if
//   Bundles the ID/EX-side request (instruction, operands, flush) and the
//   ALU-control response (aluop, stall, HI/LO, md_done, illegal) between the
//   pipeline and alu_ctrl_seq.
//   master : pipeline side, drives valid_in/ctrl/funct/src_a/src_b/flush
//   slave  : alu_ctrl_seq, drives aluop/stall/hi/lo/md_done/illegal
interface alu_ctrl_seq_if #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
);
    logic               valid_in;
    logic [3:0]         ctrl;
    logic [FUNCT_W-1:0] funct;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic               flush;
    logic [3:0]         aluop;
    logic               stall;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               md_done;
    logic               illegal;

    modport master (
        output valid_in, ctrl, funct, src_a, src_b, flush,
        input  aluop, stall, hi, lo, md_done, illegal
    );

    modport slave (
        input  valid_in, ctrl, funct, src_a, src_b, flush,
        output aluop, stall, hi, lo, md_done, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   EX-stage ALU control. Single-cycle ops are decoded combinationally to
//   aluop. MULT/MULTU/DIV/DIVU run on an iterative engine (shift-add multiply,
//   restoring divide) operating on operand magnitudes, with sign correction on
//   the last iteration; the result lands in HI/LO and md_done pulses once.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : alu_ctrl_seq_if.slave (valid_in, ctrl, funct, src_a, src_b,
//             flush in; aluop, stall, hi, lo, md_done, illegal out)
module alu_ctrl_seq #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam logic [3:0] CTRL_FUNC  = 4'b1111;
    localparam logic [3:0] CTRL_SUB_S = 4'b0001;
    localparam logic [3:0] CTRL_ADD_S = 4'b0010;
    localparam logic [3:0] CTRL_ADD_U = 4'b0011;

    localparam logic [3:0] OP_ADD_S = 4'd0;
    localparam logic [3:0] OP_ADD_U = 4'd1;
    localparam logic [3:0] OP_SUB_S = 4'd2;
    localparam logic [3:0] OP_PASS  = 4'd3;

    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b100001);
    localparam logic [FUNCT_W-1:0] F_JR    = FUNCT_W'(6'b001000);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
    localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Two's-complement negate when en is set (sign correction helpers).
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic [3:0]           aluop_c;
    logic                 is_md;
    logic                 bad_c;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   work;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     opb;       // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic                 op_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div0;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 md_done_r;

    logic                 accept;
    logic                 md_signed;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   step_work;
    logic [2*WIDTH-1:0]   fin_work;

    always_comb begin
        aluop_c = OP_ADD_S;
        is_md   = 1'b0;
        bad_c   = 1'b0;
        if (bus.ctrl == CTRL_FUNC) begin
            case (bus.funct)
                F_ADD:   aluop_c = OP_ADD_S;
                F_ADDU:  aluop_c = OP_ADD_U;
                F_JR:    aluop_c = OP_ADD_S;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    aluop_c = OP_PASS;
                    is_md   = 1'b1;
                end
                default: bad_c = 1'b1;
            endcase
        end else begin
            case (bus.ctrl)
                CTRL_SUB_S: aluop_c = OP_SUB_S;
                CTRL_ADD_S: aluop_c = OP_ADD_S;
                CTRL_ADD_U: aluop_c = OP_ADD_U;
                default:    bad_c   = 1'b1;
            endcase
        end
    end

    assign bus.aluop   = aluop_c;
    assign bus.illegal = bad_c & bus.valid_in;

    assign accept = (state == ST_IDLE) && bus.valid_in && is_md && !bus.flush;
    // Gated by rst_n so stall falls the instant reset asserts, even while the
    // held instruction is still a mul/div.
    assign bus.stall = rst_n && (accept || ((state == ST_BUSY) && !bus.flush));

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.md_done = md_done_r;

    // funct[0]=1 marks the unsigned variants, funct[1]=1 marks divide.
    assign md_signed = !bus.funct[0];
    assign a_s       = bus.src_a;
    assign b_s       = bus.src_b;
    assign mag_a     = cond_neg_w(bus.src_a, md_signed && (a_s < 0));
    assign mag_b     = cond_neg_w(bus.src_b, md_signed && (b_s < 0));

    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opb} : '0);
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ge    = (div_shift >= {1'b0, opb});
        if (op_div) begin
            step_work = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                         work[WIDTH-2:0], div_ge};
        end else begin
            step_work = {mul_sum, work[WIDTH-1:1]};
        end

        if (op_div) begin
            // Remainder follows the dividend sign; with a zero divisor the
            // remainder is the dividend itself, so that path needs no special case.
            fin_work[2*WIDTH-1:WIDTH] = cond_neg_w(step_work[2*WIDTH-1:WIDTH], neg_rem);
            fin_work[WIDTH-1:0]       = div0 ? '1 : cond_neg_w(step_work[WIDTH-1:0], neg_res);
        end else begin
            fin_work = cond_neg_2w(step_work, neg_res);
        end
    end

    // Control state: FSM, iteration counter, architectural HI/LO and md_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            md_done_r <= 1'b0;
        end else begin
            md_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    hi_r      <= work[2*WIDTH-1:WIDTH];
                    lo_r      <= work[WIDTH-1:0];
                    md_done_r <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Engine datapath: loaded on accept, one iteration per BUSY cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.funct[1]) begin
                work <= {{WIDTH{1'b0}}, mag_a};
                opb  <= mag_b;
            end else begin
                work <= {{WIDTH{1'b0}}, mag_b};
                opb  <= mag_a;
            end
            op_div  <= bus.funct[1];
            neg_res <= md_signed && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
            neg_rem <= md_signed && a_s[WIDTH-1];
            div0    <= bus.funct[1] && (bus.src_b == '0);
        end else if ((state == ST_BUSY) && !bus.flush) begin
            work <= (cnt == CNT_LAST) ? fin_work : step_work;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
//   Directed bench for alu_ctrl_seq: decode table, mul/div results with
//   hand-computed HI/LO, stall length, flush abort, async reset, and a
//   back-to-back MULT/ADD hand-off. Expected HI/LO go into a queue that a
//   separate monitor drains whenever md_done is seen.
module tb_alu_ctrl_seq;
    logic clk;
    logic rst_n;

    alu_ctrl_seq_if #(.WIDTH(32), .FUNCT_W(6)) bus ();

    alu_ctrl_seq #(.WIDTH(32), .FUNCT_W(6), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int md_cnt = 0;
    logic [63:0] exp_q[$];

    // Hand-computed decode with funct=000000 for ctrl 0..15.
    logic [3:0] dec_op  [16] = '{4'd0, 4'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0,
                                 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       dec_ill [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // funct sweep with ctrl=FUNC.
    logic [5:0] fn_val  [9] = '{6'b100000, 6'b100001, 6'b001000, 6'b011000, 6'b011001,
                                6'b011010, 6'b011011, 6'b100010, 6'b111111};
    logic [3:0] fn_op   [9] = '{4'd0, 4'd1, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0};
    logic       fn_ill  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every md_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.md_done) begin
            md_cnt++;
            if (exp_q.size() == 0) begin
                check("md_done_unexpected", 64'd1, 64'd0);
            end else begin
                check("hilo", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div, count stall cycles, optionally present ADD in DONE.
    task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit next_add);
        int n;
        int md_before;
        bit s;
        md_before = md_cnt;
        exp_q.push_back({eh, el});
        bus.valid_in = 1'b1;
        bus.ctrl     = 4'hF;
        bus.funct    = f;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.flush    = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            s = bus.stall;
            if (s) n++;
            else if (next_add) begin
                check({nm, "_done_aluop"}, bus.aluop, 4'd0);
                check({nm, "_done_illegal"}, bus.illegal, 1'b0);
            end
            tick();
            if (next_add && s && n == 33) bus.funct = 6'b100000;
        end while (s && n < 100);
        check({nm, "_stall_len"}, n, 33);
        bus.valid_in = 1'b0;
        repeat (3) tick();
        check({nm, "_md_pulses"}, md_cnt - md_before, 1);
        check({nm, "_no_reaccept"}, bus.stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int md_before;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.ctrl     = 4'd0;
        bus.funct    = 6'd0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.flush    = 1'b0;
        repeat (3) tick();
        check("rst_stall", bus.stall, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_md_done", bus.md_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Decode sweep; flush holds the FSM in IDLE while mul/div funct codes are shown.
        bus.flush    = 1'b1;
        bus.valid_in = 1'b1;
        bus.funct    = 6'd0;
        for (int i = 0; i < 16; i++) begin
            bus.ctrl = 4'(i);
            #1;
            check($sformatf("dec_op_c%0d", i), bus.aluop, dec_op[i]);
            check($sformatf("dec_ill_c%0d", i), bus.illegal, dec_ill[i]);
        end
        bus.ctrl = 4'hF;
        for (int i = 0; i < 9; i++) begin
            bus.funct = fn_val[i];
            #1;
            check($sformatf("dec_op_f%0d", i), bus.aluop, fn_op[i]);
            check($sformatf("dec_ill_f%0d", i), bus.illegal, fn_ill[i]);
        end
        bus.valid_in = 1'b0;
        bus.ctrl     = 4'b0111;
        #1;
        check("dec_c7_noval_ill", bus.illegal, 1'b0);
        check("dec_c7_noval_op", bus.aluop, 4'd0);
        bus.flush    = 1'b0;
        bus.valid_in = 1'b1;
        bus.ctrl     = 4'hF;
        bus.funct    = 6'b100000;
        #1;
        check("add_no_stall", bus.stall, 1'b0);
        bus.valid_in = 1'b0;
        tick();

        run_md("mult_m3x5",  6'b011000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_md("multu_max2", 6'b011001, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b0);
        run_md("divu_100_7", 6'b011011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_md("div_m7_2",   6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_md("div_min_m1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
        run_md("divu_9_0",   6'b011011, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b0);

        // Flush at BUSY cycle 10: no result, HI/LO keep 9 / all-ones.
        md_before    = md_cnt;
        bus.valid_in = 1'b1;
        bus.ctrl     = 4'hF;
        bus.funct    = 6'b011000;
        bus.src_a    = 32'd3;
        bus.src_b    = 32'd3;
        tick();
        repeat (10) tick();
        bus.flush    = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("flush_stall", bus.stall, 1'b0);
        tick();
        bus.flush = 1'b0;
        repeat (40) tick();
        check("flush_no_md", md_cnt - md_before, 0);
        check("flush_hi", bus.hi, 32'd9);
        check("flush_lo", bus.lo, 32'hFFFFFFFF);

        // Async reset in the middle of BUSY.
        md_before    = md_cnt;
        bus.valid_in = 1'b1;
        bus.funct    = 6'b011000;
        bus.src_a    = 32'd11;
        bus.src_b    = 32'd13;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", bus.stall, 1'b0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        bus.valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("rst_mid_no_md", md_cnt - md_before, 0);
        run_md("mult_7x6", 6'b011000, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

        // MULT with the following ADD presented during DONE.
        run_md("b2b_mult", 6'b011000, 32'd100, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFF38, 1'b1);

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        check("md_total", md_cnt, 8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
